comparador_setor_dwell: RTL and testbench
=========================================

# comparador_setor_dwell

Parametrised sector comparator for the pendulum game. It maps an N-sector target index onto a signed step/16 position range with a programmable offset. A position only counts as a hit after it stays inside the target sector for a configurable number of consecutive cycles, and hysteresis stops the in-position flag chattering at sector edges. It sits between the random target generator and the scoring/LED logic, and its `hit` pulse feeds the score counter.

## Interface
- `NUM_SETORES`, 5: number of sectors (≥2).
- `TOTAL_RANGE_STEPS16`, 3200: full range width in step/16 (180°).
- `OFFSET_STEPS16`, 0: signed lower edge of sector 0.
- `POS_WIDTH`, 16: width of the signed position.
- `DWELL_CYCLES`, 5_000_000: consecutive in-window cycles required for a hit (≥1).
- `HYST_STEPS16`, 32: hysteresis margin applied on exit (≥0, < SETOR_SIZE/2).
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: comparator runs while high.
- `target_valid` in 1: one-cycle strobe that loads `position_led`.
- `position_led` in IDX_W = $clog2(NUM_SETORES): target sector index.
- `current_position` in POS_WIDTH signed: pendulum position in step/16.
- `isInPosition` out 1: hysteresis-filtered in-sector level.
- `hit` out 1: one-cycle pulse when the dwell completes.
- `target_invalido` out 1: last loaded index was ≥ NUM_SETORES.
- `dwell_count` out $clog2(DWELL_CYCLES+1): current consecutive in-window count.

## Operation
- SETOR_SIZE = TOTAL_RANGE_STEPS16 / NUM_SETORES (integer division).
- Limits are computed on `target_valid`:
  - lo = OFFSET + idx·SETOR_SIZE.
  - hi = lo + SETOR_SIZE.
  - For the last sector, hi = OFFSET + TOTAL_RANGE_STEPS16, so the division remainder is absorbed there.
- All limit and comparison arithmetic is signed, POS_WIDTH+2 bits wide. `current_position` is sign-extended before comparison. No truncation is allowed.
- Window rules:
  - Entry window: lo ≤ pos < hi.
  - Hold window: lo−HYST ≤ pos < hi+HYST.
- States:
  - IDLE: no target, or `enable` low. Outputs are 0 and the counter is 0.
  - FORA: target loaded, position outside the entry window. Moves to DENTRO when pos is in the entry window; the counter loads 1.
  - DENTRO: counts consecutive cycles in the hold window.
    - Leaving the hold window moves to FORA and clears the counter.
    - When the counter reaches DWELL_CYCLES, `hit` pulses and the state moves to ACERTO.
  - ACERTO: locked. `isInPosition` follows the hold window, and no further `hit` occurs until the next `target_valid`. The counter saturates at DWELL_CYCLES.
- `target_valid` with a valid index:
  - Latches the limits, clears `target_invalido`, clears the counter, and moves to FORA.
  - This applies from any state except while `enable` is low; the limits are still latched then.
- `target_valid` with an index ≥ NUM_SETORES: sets `target_invalido`, moves to IDLE, and keeps the old limits unused.
- `enable` low: forces IDLE and clears the counter. Latched limits and `target_invalido` are kept. When `enable` rises, the state moves to FORA if a valid target is held.
- `isInPosition` is high only in DENTRO, and in ACERTO while in the hold window.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, limits 0, no valid target held.
- All outputs are registered.
- `target_valid` sampled at edge t: the new limits are used for samples from edge t+1. The sample at edge t is evaluated as FORA with the counter cleared.
- Position entering the entry window at sample k: `isInPosition` goes high after edge k, and `dwell_count` = 1.
- `hit` goes high for exactly one cycle after the DWELL_CYCLES-th consecutive in-window sample, at edge k+DWELL_CYCLES−1. With DWELL_CYCLES = 1, `hit` is asserted together with `isInPosition`.
- Simultaneous events:
  - `target_valid` and dwell completion on the same edge: `target_valid` wins and `hit` is not asserted.
  - `reset` overrides everything.
  - `enable` low overrides `target_valid` state transitions.
- Reset mid-dwell: the counter is lost and no `hit` occurs.

## Structure
- Shared package `comparador_pkg` holds:
  - the state enum (IDLE, FORA, DENTRO, ACERTO);
  - the SETOR_SIZE and limit-width helper functions.
- Sub-module `calculador_limites`: combinational index → lo/hi with last-sector remainder handling, instantiated once and registered at the top level.

## Test plan
Bench settings: DWELL_CYCLES=4, HYST=32, default parameters unless stated.
1. Load sector 2 (lo=1280, hi=1920); pos=1500 held for 4 cycles → `isInPosition` high 1 cycle after the first sample; `hit` pulses exactly once at the 4th sample; `dwell_count` saturates at 4.
2. Sector 2; pos=1500 for 2 cycles, then 1900, then 1930 (inside hysteresis), then 1960 → stays DENTRO through 1930; exits at 1960; counter clears; no `hit`.
3. Sector 2; pos=1260 (outside entry, inside hold) → no entry; then 1280 → entry with counter 1 (lower bound inclusive); pos=1920 from FORA → no entry (upper bound exclusive).
4. NUM_SETORES=3, TOTAL=3200: sector 2 gives lo=2132, hi=3200 → pos=3199 in window, pos=3200 out. OFFSET=−1600: sector 0 accepts −1600.
5. `target_valid` with idx 6 → `target_invalido`=1, IDLE, outputs 0. Then idx 1 → flag clears, FORA.
6. `target_valid` coincident with the 4th in-window sample → no `hit`, counter 0, FORA with the new limits. `reset` during DENTRO → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/comparador_pkg.sv
// Shared types and helpers for the pendulum sector comparator.
// Holds the FSM state enum and the sector/limit sizing functions.
package comparador_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFora,
        StDentro,
        StAcerto
    } state_e;

    // Sector width; the division remainder is absorbed by the last sector.
    function automatic int setor_size(input int total_range, input int num_setores);
        return total_range / num_setores;
    endfunction

    // Two guard bits keep offset + range + hysteresis free of overflow.
    function automatic int lim_width(input int pos_width);
        return pos_width + 2;
    endfunction

endpackage

// File: rtl/comparador_setor_dwell_calculador_limites.sv
// Combinational sector index -> [lo, hi) limits in step/16.
// The last sector ends exactly at OFFSET + TOTAL so no range is lost to rounding.
module calculador_limites
    import comparador_pkg::*;
#(
    parameter int NUM_SETORES         = 5,
    parameter int TOTAL_RANGE_STEPS16 = 3200,
    parameter int OFFSET_STEPS16      = 0,
    parameter int POS_WIDTH           = 16,
    parameter int IDX_W               = $clog2(NUM_SETORES),
    parameter int LW                  = lim_width(POS_WIDTH)
) (
    input  logic [IDX_W-1:0]     idx_i,
    output logic signed [LW-1:0] lo_o,
    output logic signed [LW-1:0] hi_o,
    output logic                 valid_o
);

    localparam int SETOR_SIZE = setor_size(TOTAL_RANGE_STEPS16, NUM_SETORES);

    localparam logic signed [LW-1:0] SIZE_S = LW'(SETOR_SIZE);
    localparam logic signed [LW-1:0] OFF_S  = LW'(OFFSET_STEPS16);
    localparam logic signed [LW-1:0] TOP_S  = LW'(OFFSET_STEPS16 + TOTAL_RANGE_STEPS16);

    logic signed [LW-1:0] idx_s;

    always_comb begin
        idx_s   = $signed({{(LW-IDX_W){1'b0}}, idx_i});
        lo_o    = OFF_S + idx_s * SIZE_S;
        hi_o    = (idx_i == IDX_W'(NUM_SETORES - 1)) ? TOP_S : lo_o + SIZE_S;
        // Extra bit so a power-of-two sector count still compares correctly.
        valid_o = ({1'b0, idx_i} < (IDX_W+1)'(NUM_SETORES));
    end

endmodule

// File: rtl/comparador_setor_dwell.sv
// Sector comparator with dwell qualification and exit hysteresis.
// Emits a one-cycle hit once the position holds inside the target sector long enough.
module comparador_setor_dwell
    import comparador_pkg::*;
#(
    parameter int NUM_SETORES         = 5,
    parameter int TOTAL_RANGE_STEPS16 = 3200,
    parameter int OFFSET_STEPS16      = 0,
    parameter int POS_WIDTH           = 16,
    parameter int DWELL_CYCLES        = 5_000_000,
    parameter int HYST_STEPS16        = 32
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    enable,
    input  logic                                    target_valid,
    input  logic [$clog2(NUM_SETORES)-1:0]          position_led,
    input  logic signed [POS_WIDTH-1:0]             current_position,
    output logic                                    isInPosition,
    output logic                                    hit,
    output logic                                    target_invalido,
    output logic [$clog2(DWELL_CYCLES+1)-1:0]       dwell_count
);

    localparam int IDX_W = $clog2(NUM_SETORES);
    localparam int LW    = lim_width(POS_WIDTH);
    localparam int CW    = $clog2(DWELL_CYCLES + 1);

    localparam logic [CW-1:0]        DWELL_C = CW'(DWELL_CYCLES);
    localparam logic [CW-1:0]        ONE_C   = CW'(1);
    localparam logic signed [LW-1:0] HYST_S  = LW'(HYST_STEPS16);

    state_e               state_q, state_d;
    logic signed [LW-1:0] lo_q, lo_d, hi_q, hi_d;
    logic                 tgt_ok_q, tgt_ok_d;
    logic                 inval_q, inval_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 in_pos_q, in_pos_d;
    logic                 hit_q, hit_d;

    logic signed [LW-1:0] calc_lo, calc_hi;
    logic                 calc_valid;
    logic signed [LW-1:0] pos_s;
    logic                 in_entry, in_hold;

    calculador_limites #(
        .NUM_SETORES         (NUM_SETORES),
        .TOTAL_RANGE_STEPS16 (TOTAL_RANGE_STEPS16),
        .OFFSET_STEPS16      (OFFSET_STEPS16),
        .POS_WIDTH           (POS_WIDTH),
        .IDX_W               (IDX_W),
        .LW                  (LW)
    ) u_calculador_limites (
        .idx_i   (position_led),
        .lo_o    (calc_lo),
        .hi_o    (calc_hi),
        .valid_o (calc_valid)
    );

    always_comb begin
        pos_s    = $signed({{(LW-POS_WIDTH){current_position[POS_WIDTH-1]}}, current_position});
        in_entry = (pos_s >= lo_q) && (pos_s < hi_q);
        in_hold  = (pos_s >= lo_q - HYST_S) && (pos_s < hi_q + HYST_S);
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        tgt_ok_d = tgt_ok_q;
        inval_d  = inval_q;
        count_d  = count_q;
        in_pos_d = 1'b0;
        hit_d    = 1'b0;

        // Limits and the invalid flag track target_valid even while disabled.
        if (target_valid) begin
            if (calc_valid) begin
                lo_d     = calc_lo;
                hi_d     = calc_hi;
                tgt_ok_d = 1'b1;
                inval_d  = 1'b0;
            end else begin
                tgt_ok_d = 1'b0;
                inval_d  = 1'b1;
            end
        end

        if (!enable) begin
            state_d = StIdle;
            count_d = '0;
        end else if (target_valid) begin
            state_d = calc_valid ? StFora : StIdle;
            count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    count_d = '0;
                    if (tgt_ok_q) state_d = StFora;
                end
                StFora: begin
                    if (in_entry) begin
                        count_d  = ONE_C;
                        in_pos_d = 1'b1;
                        if (DWELL_C == ONE_C) begin
                            hit_d   = 1'b1;
                            state_d = StAcerto;
                        end else begin
                            state_d = StDentro;
                        end
                    end else begin
                        count_d = '0;
                    end
                end
                StDentro: begin
                    if (in_hold) begin
                        count_d  = count_q + ONE_C;
                        in_pos_d = 1'b1;
                        if (count_q + ONE_C == DWELL_C) begin
                            hit_d   = 1'b1;
                            state_d = StAcerto;
                        end
                    end else begin
                        count_d = '0;
                        state_d = StFora;
                    end
                end
                StAcerto: begin
                    in_pos_d = in_hold;
                    count_d  = DWELL_C;
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            hi_q     <= '0;
            tgt_ok_q <= 1'b0;
            inval_q  <= 1'b0;
            count_q  <= '0;
            in_pos_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            tgt_ok_q <= tgt_ok_d;
            inval_q  <= inval_d;
            count_q  <= count_d;
            in_pos_q <= in_pos_d;
            hit_q    <= hit_d;
        end
    end

    always_comb begin
        isInPosition    = in_pos_q;
        hit             = hit_q;
        target_invalido = inval_q;
        dwell_count     = count_q;
    end

endmodule

// File: tb/tb_comparador_setor_dwell.sv
// Directed bench for comparador_setor_dwell: dwell, hysteresis, bounds, parameters,
// invalid targets, enable gating and simultaneous-event priority.
module tb_comparador_setor_dwell;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               target_valid;
    logic [2:0]         led5;
    logic [1:0]         led3;
    logic [2:0]         ledo;
    logic signed [15:0] pos;

    logic       in_m, hit_m, inv_m;
    logic [2:0] cnt_m;
    logic       in_n3, hit_n3, inv_n3;
    logic [2:0] cnt_n3;
    logic       in_o, hit_o, inv_o;
    logic [2:0] cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    comparador_setor_dwell #(
        .DWELL_CYCLES (4),
        .HYST_STEPS16 (32)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .target_valid     (target_valid),
        .position_led     (led5),
        .current_position (pos),
        .isInPosition     (in_m),
        .hit              (hit_m),
        .target_invalido  (inv_m),
        .dwell_count      (cnt_m)
    );

    comparador_setor_dwell #(
        .NUM_SETORES  (3),
        .DWELL_CYCLES (4),
        .HYST_STEPS16 (32)
    ) dut_n3 (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .target_valid     (target_valid),
        .position_led     (led3),
        .current_position (pos),
        .isInPosition     (in_n3),
        .hit              (hit_n3),
        .target_invalido  (inv_n3),
        .dwell_count      (cnt_n3)
    );

    comparador_setor_dwell #(
        .OFFSET_STEPS16 (-1600),
        .DWELL_CYCLES   (4),
        .HYST_STEPS16   (32)
    ) dut_off (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .target_valid     (target_valid),
        .position_led     (ledo),
        .current_position (pos),
        .isInPosition     (in_o),
        .hit              (hit_o),
        .target_invalido  (inv_o),
        .dwell_count      (cnt_o)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [2:0] i5, input logic [1:0] i3, input logic [2:0] io);
        target_valid = 1'b1;
        led5 = i5;
        led3 = i3;
        ledo = io;
        step();
        target_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; target_valid = 1'b0;
        led5 = 3'd0; led3 = 2'd0; ledo = 3'd0; pos = 16'sd1500;
        step(); step();
        checks++;
        if ({in_m, hit_m, inv_m, cnt_m} !== 6'b0) begin
            failures++;
            $display("FAIL reset_main got=%b exp=%b", {in_m, hit_m, inv_m, cnt_m}, 6'b0);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({in_m, hit_m, cnt_m} !== 5'b0) begin
            failures++;
            $display("FAIL reset_no_target got=%b exp=%b", {in_m, hit_m, cnt_m}, 5'b0);
        end
    endtask

    task automatic test_dwell();
        logic [4:0] exp_v [5];
        exp_v[0] = 5'b1_0_001; exp_v[1] = 5'b1_0_010; exp_v[2] = 5'b1_0_011;
        exp_v[3] = 5'b1_1_100; exp_v[4] = 5'b1_0_100;
        pos = 16'sd0;
        load(3'd2, 2'd0, 3'd0);
        pos = 16'sd1500;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({in_m, hit_m, cnt_m} !== exp_v[i]) begin
                failures++;
                $display("FAIL dwell_s%0d got=%b exp=%b", i, {in_m, hit_m, cnt_m}, exp_v[i]);
            end
        end
    endtask

    task automatic test_hysteresis();
        logic signed [15:0] p [4];
        logic [4:0]         exp_v [4];
        p[0] = 16'sd1500; p[1] = 16'sd1900; p[2] = 16'sd1930; p[3] = 16'sd1960;
        exp_v[0] = 5'b1_0_001; exp_v[1] = 5'b1_0_010; exp_v[2] = 5'b1_0_011;
        exp_v[3] = 5'b0_0_000;
        load(3'd2, 2'd0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            pos = p[i];
            step();
            checks++;
            if ({in_m, hit_m, cnt_m} !== exp_v[i]) begin
                failures++;
                $display("FAIL hyst_%0d got=%b exp=%b", p[i], {in_m, hit_m, cnt_m}, exp_v[i]);
            end
        end
    endtask

    task automatic test_bounds();
        logic signed [15:0] p [4];
        logic [4:0]         exp_v [4];
        p[0] = 16'sd1260; p[1] = 16'sd1280; p[2] = 16'sd0; p[3] = 16'sd1920;
        exp_v[0] = 5'b0_0_000; exp_v[1] = 5'b1_0_001; exp_v[2] = 5'b0_0_000;
        exp_v[3] = 5'b0_0_000;
        load(3'd2, 2'd0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            pos = p[i];
            step();
            checks++;
            if ({in_m, hit_m, cnt_m} !== exp_v[i]) begin
                failures++;
                $display("FAIL bound_%0d got=%b exp=%b", p[i], {in_m, hit_m, cnt_m}, exp_v[i]);
            end
        end
    endtask

    task automatic test_params();
        logic signed [15:0] p [4];
        logic [1:0]         exp_v [4];
        // {in_n3, in_o}: n3 sector 2 is [2132,3200), offset sector 0 is [-1600,-960)
        p[0] = 16'sd3200; p[1] = -16'sd1601; p[2] = 16'sd3199; p[3] = -16'sd1600;
        exp_v[0] = 2'b00; exp_v[1] = 2'b00; exp_v[2] = 2'b10; exp_v[3] = 2'b01;
        load(3'd0, 2'd2, 3'd0);
        for (int i = 0; i < 4; i++) begin
            pos = p[i];
            step();
            checks++;
            if ({in_n3, in_o} !== exp_v[i]) begin
                failures++;
                $display("FAIL param_%0d got=%b exp=%b", p[i], {in_n3, in_o}, exp_v[i]);
            end
        end
    endtask

    task automatic test_invalid();
        pos = 16'sd1500;
        load(3'd6, 2'd0, 3'd0);
        checks++;
        if ({in_m, hit_m, inv_m, cnt_m} !== 6'b001_000) begin
            failures++;
            $display("FAIL inval_set got=%b exp=%b", {in_m, hit_m, inv_m, cnt_m}, 6'b001_000);
        end
        step();
        checks++;
        if ({in_m, hit_m, inv_m, cnt_m} !== 6'b001_000) begin
            failures++;
            $display("FAIL inval_idle got=%b exp=%b", {in_m, hit_m, inv_m, cnt_m}, 6'b001_000);
        end
        load(3'd1, 2'd0, 3'd0);
        checks++;
        if (inv_m !== 1'b0) begin
            failures++;
            $display("FAIL inval_clear got=%b exp=0", inv_m);
        end
        pos = 16'sd700;
        step();
        checks++;
        if ({in_m, hit_m, cnt_m} !== 5'b1_0_001) begin
            failures++;
            $display("FAIL inval_reentry got=%b exp=%b", {in_m, hit_m, cnt_m}, 5'b1_0_001);
        end
    endtask

    task automatic test_enable();
        load(3'd2, 2'd0, 3'd0);
        pos = 16'sd1500;
        step();
        enable = 1'b0;
        step();
        checks++;
        if ({in_m, hit_m, cnt_m} !== 5'b0) begin
            failures++;
            $display("FAIL enable_low got=%b exp=%b", {in_m, hit_m, cnt_m}, 5'b0);
        end
        enable = 1'b1;
        step();
        step();
        checks++;
        if ({in_m, hit_m, cnt_m} !== 5'b1_0_001) begin
            failures++;
            $display("FAIL enable_resume got=%b exp=%b", {in_m, hit_m, cnt_m}, 5'b1_0_001);
        end
    endtask

    task automatic test_back_to_back();
        load(3'd2, 2'd0, 3'd0);
        pos = 16'sd1500;
        step(); step(); step();
        target_valid = 1'b1;
        led5 = 3'd1;
        step();
        target_valid = 1'b0;
        checks++;
        if ({in_m, hit_m, cnt_m} !== 5'b0) begin
            failures++;
            $display("FAIL tv_vs_hit got=%b exp=%b", {in_m, hit_m, cnt_m}, 5'b0);
        end
        step();
        checks++;
        if ({in_m, hit_m, cnt_m} !== 5'b0) begin
            failures++;
            $display("FAIL new_limits_out got=%b exp=%b", {in_m, hit_m, cnt_m}, 5'b0);
        end
        pos = 16'sd700;
        step(); step();
        checks++;
        if ({in_m, hit_m, cnt_m} !== 5'b1_0_010) begin
            failures++;
            $display("FAIL new_limits_in got=%b exp=%b", {in_m, hit_m, cnt_m}, 5'b1_0_010);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({in_m, hit_m, inv_m, cnt_m} !== 6'b0) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=%b", {in_m, hit_m, inv_m, cnt_m}, 6'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({in_m, hit_m, cnt_m} !== 5'b0) begin
                failures++;
                $display("FAIL post_reset_%0d got=%b exp=%b", i, {in_m, hit_m, cnt_m}, 5'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dwell();
        test_hysteresis();
        test_bounds();
        test_params();
        test_invalid();
        test_enable();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
